// File: rtl/alu_branch_control_if.sv
// Datapath-facing bundle of the execute-stage core: operands and instruction in,
// decoded controls, branch flags and ALU result out.
interface alu_branch_control_if;
    logic        en;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        BEq;
    logic        BLT;
    logic        PCsel;
    logic        RegWen;
    logic        BrUn;
    logic        Bsel;
    logic        Asel;
    logic [4:0]  AluOp;
    logic        WbSel;
    logic        MemRW;
    logic [31:0] ALUout;

    modport master (
        output en, instr, rs1, rs2, opA, opB,
        input  BEq, BLT, PCsel, RegWen, BrUn, Bsel, Asel, AluOp, WbSel, MemRW, ALUout
    );

    modport slave (
        input  en, instr, rs1, rs2, opA, opB,
        output BEq, BLT, PCsel, RegWen, BrUn, Bsel, Asel, AluOp, WbSel, MemRW, ALUout
    );
endinterface

// File: rtl/alu_branch_control.sv
// RV32I execute-stage core: registered instruction decode, combinational branch
// comparison and a registered 32-bit ALU driven by the registered AluOp.
module alu_branch_control (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_branch_control_if.slave  bus
);
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_PASS = 5'd10;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt_bit;
    logic        un;
    logic        beq_flag;
    logic        blt_flag;

    logic        pc_sel_next,  pc_sel_reg;
    logic        reg_wen_next, reg_wen_reg;
    logic        br_un_next,   br_un_reg;
    logic        b_sel_next,   b_sel_reg;
    logic        a_sel_next,   a_sel_reg;
    logic [4:0]  alu_op_next,  alu_op_reg;
    logic        wb_sel_next,  wb_sel_reg;
    logic        mem_rw_next,  mem_rw_reg;
    logic [31:0] alu_next,     alu_reg;
    logic [4:0]  shamt;

    assign opcode  = bus.instr[6:0];
    assign funct3  = bus.instr[14:12];
    assign alt_bit = bus.instr[30];

    // Signedness comes from the instruction being compared now, not from BrUn.
    assign un       = (opcode == OPC_BRANCH) && bus.instr[13];
    assign beq_flag = (bus.rs1 == bus.rs2);
    assign blt_flag = un ? (bus.rs1 < bus.rs2)
                         : ($signed(bus.rs1) < $signed(bus.rs2));

    function automatic logic [4:0] f3_to_op(input logic [2:0] f3, input logic alt,
                                            input logic allow_sub);
        logic [4:0] op;
        op = OP_ADD;
        case (f3)
            3'b000:  op = (allow_sub && alt) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        pc_sel_next  = 1'b0;
        reg_wen_next = 1'b0;
        br_un_next   = 1'b0;
        b_sel_next   = 1'b0;
        a_sel_next   = 1'b0;
        alu_op_next  = OP_ADD;
        wb_sel_next  = 1'b0;
        mem_rw_next  = 1'b0;
        case (opcode)
            OPC_R: begin
                reg_wen_next = 1'b1;
                wb_sel_next  = 1'b1;
                alu_op_next  = f3_to_op(funct3, alt_bit, 1'b1);
            end
            OPC_I: begin
                reg_wen_next = 1'b1;
                b_sel_next   = 1'b1;
                wb_sel_next  = 1'b1;
                alu_op_next  = f3_to_op(funct3, alt_bit, 1'b0);
            end
            OPC_LOAD: begin
                reg_wen_next = 1'b1;
                b_sel_next   = 1'b1;
            end
            OPC_STORE: begin
                b_sel_next  = 1'b1;
                wb_sel_next = 1'b1;
                mem_rw_next = 1'b1;
            end
            OPC_BRANCH: begin
                a_sel_next  = 1'b1;
                b_sel_next  = 1'b1;
                wb_sel_next = 1'b1;
                br_un_next  = un;
                case (funct3)
                    3'b000:          pc_sel_next = beq_flag;
                    3'b001:          pc_sel_next = !beq_flag;
                    3'b100, 3'b110:  pc_sel_next = blt_flag;
                    3'b101, 3'b111:  pc_sel_next = !blt_flag;
                    default:         pc_sel_next = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // The ALU consumes the registered AluOp, so it trails decode by one cycle.
    assign shamt = bus.opB[4:0];
    always_comb begin
        alu_next = 32'd0;
        case (alu_op_reg)
            OP_ADD:  alu_next = bus.opA + bus.opB;
            OP_SUB:  alu_next = bus.opA - bus.opB;
            OP_SLL:  alu_next = bus.opA << shamt;
            OP_SLT:  alu_next = {31'd0, $signed(bus.opA) < $signed(bus.opB)};
            OP_SLTU: alu_next = {31'd0, bus.opA < bus.opB};
            OP_XOR:  alu_next = bus.opA ^ bus.opB;
            OP_SRL:  alu_next = bus.opA >> shamt;
            OP_SRA:  alu_next = $unsigned($signed(bus.opA) >>> shamt);
            OP_OR:   alu_next = bus.opA | bus.opB;
            OP_AND:  alu_next = bus.opA & bus.opB;
            OP_PASS: alu_next = bus.opB;
            default: alu_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_sel_reg  <= 1'b0;
            reg_wen_reg <= 1'b0;
            br_un_reg   <= 1'b0;
            b_sel_reg   <= 1'b0;
            a_sel_reg   <= 1'b0;
            alu_op_reg  <= 5'd0;
            wb_sel_reg  <= 1'b0;
            mem_rw_reg  <= 1'b0;
            alu_reg     <= 32'd0;
        end else begin
            pc_sel_reg  <= pc_sel_next;
            reg_wen_reg <= reg_wen_next;
            br_un_reg   <= br_un_next;
            b_sel_reg   <= b_sel_next;
            a_sel_reg   <= a_sel_next;
            alu_op_reg  <= alu_op_next;
            wb_sel_reg  <= wb_sel_next;
            mem_rw_reg  <= mem_rw_next;
            if (bus.en) begin
                alu_reg <= alu_next;
            end
        end
    end

    assign bus.BEq    = beq_flag;
    assign bus.BLT    = blt_flag;
    assign bus.PCsel  = pc_sel_reg;
    assign bus.RegWen = reg_wen_reg;
    assign bus.BrUn   = br_un_reg;
    assign bus.Bsel   = b_sel_reg;
    assign bus.Asel   = a_sel_reg;
    assign bus.AluOp  = alu_op_reg;
    assign bus.WbSel  = wb_sel_reg;
    assign bus.MemRW  = mem_rw_reg;
    assign bus.ALUout = alu_reg;
endmodule

// File: tb/tb_alu_branch_control.sv
// Directed bench for alu_branch_control: hand-encoded RV32I instructions with
// hand-computed expected controls, branch flags and ALU results.
module tb_alu_branch_control;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    alu_branch_control_if bus ();

    alu_branch_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4040D093;
    localparam logic [31:0] I_ADDI = 32'h40000093;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0050A023;
    localparam logic [31:0] I_BLT  = 32'h0020C063;
    localparam logic [31:0] I_BLTU = 32'h0020E063;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BNE  = 32'h00209063;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs the registered controls as {PCsel,RegWen,BrUn,Bsel,Asel,WbSel,MemRW,AluOp}.
    function automatic logic [31:0] ctrl_word();
        return {20'd0, bus.PCsel, bus.RegWen, bus.BrUn, bus.Bsel, bus.Asel,
                bus.WbSel, bus.MemRW, bus.AluOp};
    endfunction

    function automatic logic [31:0] mk_ctrl(input logic pcsel, input logic regwen,
                                            input logic brun, input logic bsel,
                                            input logic asel, input logic wbsel,
                                            input logic memrw, input logic [4:0] op);
        return {20'd0, pcsel, regwen, brun, bsel, asel, wbsel, memrw, op};
    endfunction

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        bus.en    = 1'b1;
        bus.instr = I_SUB;
        bus.rs1   = 32'd0;
        bus.rs2   = 32'd0;
        bus.opA   = 32'd5;
        bus.opB   = 32'd7;

        // Reset with a live instruction and en=1: reset must win.
        step();
        step();
        check_value("reset_ctrl", ctrl_word(), 32'd0);
        check_value("reset_aluout", bus.ALUout, 32'd0);

        rst_n     = 1'b1;
        bus.en    = 1'b0;
        bus.instr = 32'd0;
        step();
        check_value("nop_ctrl", ctrl_word(), 32'd0);

        // sub x3,x1,x2 then 5 - 7
        bus.instr = I_SUB;
        step();
        check_value("sub_ctrl", ctrl_word(), mk_ctrl(0, 1, 0, 0, 0, 1, 0, 5'd1));
        bus.opA = 32'd5;
        bus.opB = 32'd7;
        bus.en  = 1'b1;
        step();
        check_value("sub_aluout", bus.ALUout, 32'hFFFFFFFE);

        // en=0 holds the result even with new operands
        bus.en  = 1'b0;
        bus.opA = 32'd100;
        step();
        check_value("hold_aluout", bus.ALUout, 32'hFFFFFFFE);

        // srai x1,x1,4
        bus.instr = I_SRAI;
        step();
        check_value("srai_ctrl", ctrl_word(), mk_ctrl(0, 1, 0, 1, 0, 1, 0, 5'd7));
        bus.opA = 32'h80000000;
        bus.opB = 32'd4;
        bus.en  = 1'b1;
        step();
        check_value("srai_aluout", bus.ALUout, 32'hF8000000);

        // addi with instr[30] set stays ADD
        bus.instr = I_ADDI;
        step();
        check_value("addi_ctrl", ctrl_word(), mk_ctrl(0, 1, 0, 1, 0, 1, 0, 5'd0));
        bus.opA = 32'd3;
        bus.opB = 32'd1024;
        step();
        check_value("addi_aluout", bus.ALUout, 32'd1027);

        bus.instr = I_LW;
        step();
        check_value("lw_ctrl", ctrl_word(), mk_ctrl(0, 1, 0, 1, 0, 0, 0, 5'd0));
        bus.instr = I_SW;
        step();
        check_value("sw_ctrl", ctrl_word(), mk_ctrl(0, 0, 0, 1, 0, 1, 1, 5'd0));

        // Branches with rs1=-1, rs2=1
        bus.rs1   = 32'hFFFFFFFF;
        bus.rs2   = 32'd1;
        bus.instr = I_BLT;
        #1;
        check_value("blt_BLT", {31'd0, bus.BLT}, 32'd1);
        check_value("blt_BEq", {31'd0, bus.BEq}, 32'd0);
        step();
        check_value("blt_ctrl", ctrl_word(), mk_ctrl(1, 0, 0, 1, 1, 1, 0, 5'd0));

        bus.instr = I_BLTU;
        #1;
        check_value("bltu_BLT", {31'd0, bus.BLT}, 32'd0);
        step();
        check_value("bltu_ctrl", ctrl_word(), mk_ctrl(0, 0, 1, 1, 1, 1, 0, 5'd0));

        bus.rs1   = 32'd9;
        bus.rs2   = 32'd9;
        bus.instr = I_BEQ;
        #1;
        check_value("beq_BEq", {31'd0, bus.BEq}, 32'd1);
        step();
        check_value("beq_ctrl", ctrl_word(), mk_ctrl(1, 0, 0, 1, 1, 1, 0, 5'd0));

        bus.instr = I_BNE;
        step();
        check_value("bne_ctrl", ctrl_word(), mk_ctrl(0, 0, 0, 1, 1, 1, 0, 5'd0));

        // slt / sltu with -1 vs 1
        bus.instr = I_SLT;
        step();
        check_value("slt_aluop", {27'd0, bus.AluOp}, 32'd3);
        bus.opA = 32'hFFFFFFFF;
        bus.opB = 32'd1;
        step();
        check_value("slt_aluout", bus.ALUout, 32'd1);

        bus.instr = I_SLTU;
        step();
        check_value("sltu_aluop", {27'd0, bus.AluOp}, 32'd4);
        step();
        check_value("sltu_aluout", bus.ALUout, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
